// File: rtl/pool_job_sequencer.sv
// pool_job_sequencer: job controller between UART RX/TX and the pooling engine
// Parses a mode header, loads IN_BYTES image bytes into the engine input BRAM,
// runs the engine, then streams OUT_BYTES results from its output BRAM to UART TX.
// Ports:
//   clk, reset           clock, async active-high reset
//   rx_valid, rx_data    received UART byte strobe and data
//   tx_ready             UART TX can accept a byte
//   tx_valid, tx_data    byte offered to UART TX
//   pool_rst             one-cycle engine reset at job start
//   pool_start           engine start, also engine BRAM port select (0 = external write)
//   pool_mode            pooling mode from the header
//   pool_done            engine finished
//   wbram, wbram_data,
//   wbram_addr           input BRAM write port
//   infer_addr,
//   infer_dout           output BRAM read port
//   busy                 job in progress
//   hdr_err              one-cycle pulse on a dropped bad header
//   seq_state            current state, for debug
module pool_job_sequencer #(
    parameter int         IN_BYTES  = 16384,
    parameter int         OUT_BYTES = 3969,
    parameter int         RD_LAT    = 3,
    parameter logic [5:0] HDR_TAG   = 6'b101010
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic        tx_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    output logic        pool_rst,
    output logic        pool_start,
    output logic [1:0]  pool_mode,
    input  logic        pool_done,
    output logic        wbram,
    output logic [7:0]  wbram_data,
    output logic [13:0] wbram_addr,
    output logic [15:0] infer_addr,
    input  logic [7:0]  infer_dout,
    output logic        busy,
    output logic        hdr_err,
    output logic [2:0]  seq_state
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] LOAD    = 3'd1;
    localparam logic [2:0] RUN     = 3'd2;
    localparam logic [2:0] FETCH   = 3'd3;
    localparam logic [2:0] WAIT_RD = 3'd4;
    localparam logic [2:0] SEND    = 3'd5;
    localparam int LW = $clog2(RD_LAT + 1);

    logic [2:0]    state;
    logic [13:0]   load_cnt;
    logic [15:0]   rd_cnt;
    logic [LW-1:0] lat_cnt;

    assign seq_state = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            tx_valid   <= 1'b0;
            tx_data    <= '0;
            pool_rst   <= 1'b0;
            pool_start <= 1'b0;
            pool_mode  <= '0;
            wbram      <= 1'b0;
            wbram_data <= '0;
            wbram_addr <= '0;
            infer_addr <= '0;
            busy       <= 1'b0;
            hdr_err    <= 1'b0;
            load_cnt   <= '0;
            rd_cnt     <= '0;
            lat_cnt    <= '0;
        end else begin
            pool_rst <= 1'b0;
            hdr_err  <= 1'b0;
            wbram    <= 1'b0;
            case (state)
                IDLE: if (rx_valid) begin
                    if (rx_data[7:2] == HDR_TAG) begin
                        pool_mode <= rx_data[1:0];
                        pool_rst  <= 1'b1;
                        load_cnt  <= '0;
                        busy      <= 1'b1;
                        state     <= LOAD;
                    end else
                        hdr_err <= 1'b1;
                end
                LOAD: begin
                    pool_start <= 1'b0;
                    if (rx_valid) begin
                        wbram      <= 1'b1;
                        wbram_data <= rx_data;
                        wbram_addr <= load_cnt;
                        load_cnt   <= load_cnt + 1'b1;
                        if (load_cnt == 14'(IN_BYTES - 1))
                            state <= RUN;
                    end
                end
                // pool_start rises only after the last write has left the write port
                RUN: begin
                    pool_start <= 1'b1;
                    if (pool_done) begin
                        rd_cnt     <= '0;
                        infer_addr <= '0;
                        state      <= FETCH;
                    end
                end
                // the address was already presented on entry, so FETCH counts toward RD_LAT
                FETCH: begin
                    infer_addr <= rd_cnt;
                    lat_cnt    <= '0;
                    state      <= WAIT_RD;
                end
                WAIT_RD: begin
                    lat_cnt <= lat_cnt + 1'b1;
                    if (lat_cnt == LW'(RD_LAT - 1)) begin
                        tx_data  <= infer_dout;
                        tx_valid <= 1'b1;
                        state    <= SEND;
                    end
                end
                SEND: if (tx_ready) begin
                    tx_valid <= 1'b0;
                    rd_cnt   <= rd_cnt + 1'b1;
                    if (rd_cnt == 16'(OUT_BYTES - 1)) begin
                        pool_start <= 1'b0;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        infer_addr <= rd_cnt + 1'b1;
                        state      <= FETCH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/pool_job_sequencer.md
Name: pool_job_sequencer

Overview:
- Top-level job controller between the UART RX/TX byte interfaces and the pooling engine.
- Parses a one-byte header that selects the pooling mode, then streams IN_BYTES image bytes into the engine's input BRAM through its write port.
- Starts pooling, waits for done, then reads OUT_BYTES results back through the engine's inference read port and hands them to UART TX one byte at a time.
- Owns the engine's start and reset, so back-to-back jobs need no external intervention.

Parameters:
- IN_BYTES, 16384, image bytes per job (128x128).
- OUT_BYTES, 3969, pooled bytes per job (63x63).
- RD_LAT, 3, cycles from an infer_addr change until infer_dout is valid.
- HDR_TAG, 6'b101010, required value of header bits [7:2].

Ports:
- clk  in  1  system clock
- reset  in  1  async active-high reset
- rx_valid  in  1  one-cycle strobe, rx_data valid
- rx_data  in  8  received byte
- tx_ready  in  1  UART TX can accept a byte this cycle
- tx_valid  out  1  tx_data valid; byte transfers when tx_valid && tx_ready
- tx_data  out  8  pooled byte to transmit
- pool_rst  out  1  reset pulse to the pooling engine
- pool_start  out  1  engine start; also selects the engine BRAM port (0 = external write)
- pool_mode  out  2  pooling mode (0 BWAD, 1 AMD, 2 MAX, 3 AAD)
- pool_done  in  1  engine finished, output BRAM readable
- wbram  out  1  input BRAM write strobe
- wbram_data  out  8  input BRAM write data
- wbram_addr  out  14  input BRAM write address
- infer_addr  out  16  output BRAM read address
- infer_dout  in  8  output BRAM read data
- busy  out  1  high in every state except IDLE
- hdr_err  out  1  one-cycle pulse when a bad header byte is dropped
- seq_state  out  3  current state encoding, for debug

Behaviour:
- Reset (async) drives: state IDLE; tx_valid=0; tx_data=0; pool_rst=0; pool_start=0; pool_mode=0; wbram=0; wbram_data=0; wbram_addr=0; infer_addr=0; busy=0; hdr_err=0; all counters 0. Reset mid-job abandons the job; no partial output is produced.
- All outputs are registered. Encodings: IDLE=0, LOAD=1, RUN=2, FETCH=3, WAIT_RD=4, SEND=5.
- IDLE, on rx_valid:
  - if rx_data[7:2]==HDR_TAG: latch pool_mode=rx_data[1:0], pulse pool_rst high for exactly 1 cycle, clear the load counter, go to LOAD;
  - otherwise pulse hdr_err for 1 cycle and stay in IDLE.
- LOAD:
  - pool_start=0.
  - Each rx_valid gives, next cycle: wbram=1 for 1 cycle, wbram_data=byte, wbram_addr=load counter; then the counter increments.
  - wbram is never held high across cycles without a new rx_valid.
  - After the write of byte IN_BYTES-1 (address 16383), go to RUN.
  - No header parsing occurs in LOAD; every byte is image data.
- RUN: assert pool_start and hold it through FETCH, WAIT_RD and SEND. rx_valid is ignored from RUN until IDLE. When pool_done=1, clear the read counter and go to FETCH.
- FETCH: infer_addr=read counter; go to WAIT_RD.
- WAIT_RD: count RD_LAT cycles, then latch tx_data=infer_dout, set tx_valid=1, go to SEND.
- SEND:
  - hold tx_valid and tx_data stable until tx_ready.
  - On transfer: tx_valid=0 next cycle and the read counter increments.
  - If the transferred byte was number OUT_BYTES-1, drop pool_start and go to IDLE; otherwise go to FETCH.
- Simultaneous events:
  - rx_valid in the same cycle as the last LOAD write: that byte is dropped.
  - pool_done already high on entry to RUN: proceed on the first RUN cycle.
- Counters: load counter 14 bits, read counter 16 bits; neither wraps, because the terminal count forces a state exit.
- Throughput: one output byte per RD_LAT+2 cycles plus TX backpressure.

Test Plan:
- Header 0xAA (mode 2) then 16384 bytes = addr & 0xFF:
  - pool_rst pulses 1 cycle;
  - 16384 single-cycle wbram writes with wbram_addr 0..16383 and data matching;
  - then pool_start rises and pool_mode=2.
- Header 0x13, then 0xA9:
  - hdr_err pulses once and the state stays IDLE;
  - then mode latches 1 and the state goes to LOAD.
- pool_done asserted with a stub BRAM returning addr[7:0] after 3 cycles, tx_ready tied 1:
  - exactly 3969 TX transfers, values 0x00..(3968 & 0xFF) in order;
  - pool_start then falls and busy goes 0.
- tx_ready held low 50 cycles during SEND: tx_valid stays 1 and tx_data stays unchanged; the byte transfers once when tx_ready rises.
- Async reset midway through LOAD (address 5000):
  - all outputs return to reset values immediately;
  - a new header plus a full job then completes correctly with pool_rst pulsed again.
- Two back-to-back jobs (mode 0 then 3): the second job's pool_rst precedes its writes, and the output count is again 3969.
